// File: rtl/snd_cmd_pkg.sv
// Shared types and status-bit positions for the sound command sender.
package snd_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT_SET,
    WAIT_CLR
  } state_t;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_SENDING = 2;
  localparam int ST_BUSY    = 3;
  localparam int ST_TIMEOUT = 6;
  localparam int ST_OVF     = 7;

endpackage

// File: rtl/snd_cmd_sender_if.sv
// Main-CPU bus side of the sound command sender: write/read strobes and status.
interface snd_cmd_sender_if;
  logic       cpu_wr;
  logic [7:0] cpu_din;
  logic       cpu_rd;
  logic [7:0] cpu_dout;

  modport master (output cpu_wr, cpu_din, cpu_rd, input cpu_dout);
  modport slave  (input cpu_wr, cpu_din, cpu_rd, output cpu_dout);
endinterface

// File: rtl/snd_cmd_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; head is read combinationally.
module snd_cmd_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wptr, rptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en, rd_en;

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: rtl/snd_cmd_sender.sv
// Queues CPU command bytes and hands them one at a time to the sound latch.
// Optional watchdog on the busy handshake: define SND_CMD_TIMEOUT_EN.
module snd_cmd_sender
  import snd_cmd_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                clk,
  input  logic                rst,
  snd_cmd_sender_if.slave     cpu,
  input  logic                SND_BUSY,
  output logic [7:0]          data_out,
  output logic                MCODE,
  output logic                fifo_full,
  output logic                fifo_empty
);
  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] head;
  logic       busy_p0, busy_sync;
  logic       pop, waiting, wd_hit;
  logic       ovf, tmo;

  snd_cmd_fifo #(.DEPTH(DEPTH), .DATA_W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cpu.cpu_wr),
    .din   (cpu.cpu_din),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // SND_BUSY comes from another board: two-stage synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_p0   <= 1'b0;
      busy_sync <= 1'b0;
    end else begin
      busy_p0   <= SND_BUSY;
      busy_sync <= busy_p0;
    end
  end

  assign pop     = (state == IDLE) && !fifo_empty && !busy_sync;
  assign waiting = (state == WAIT_SET) || (state == WAIT_CLR);

`ifdef SND_CMD_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] wd;

  assign wd_hit = waiting && (wd == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wd <= '0;
    else if (pop)               wd <= '0;
    else if (waiting && !wd_hit) wd <= wd + 16'd1;
  end
`else
  logic [15:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 16'(TIMEOUT_CYC);
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      MCODE    <= 1'b0;
      data_out <= 8'h00;
    end else begin
      case (state)
        IDLE: if (pop) begin
          data_out <= head;
          cnt      <= '0;
          state    <= SETUP;
        end
        SETUP: if (cnt == SETUP_LAST) begin
          cnt   <= '0;
          MCODE <= 1'b1;
          state <= STROBE;
        end else cnt <= cnt + 8'd1;
        STROBE: if (cnt == STROBE_LAST) begin
          MCODE <= 1'b0;
          state <= WAIT_SET;
        end else cnt <= cnt + 8'd1;
        WAIT_SET: if (wd_hit) state <= IDLE;
          else if (busy_sync) state <= WAIT_CLR;
        WAIT_CLR: if (wd_hit || !busy_sync) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A fresh overflow/timeout in the same cycle as a status read keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      tmo <= 1'b0;
    end else begin
      if (cpu.cpu_wr && fifo_full) ovf <= 1'b1;
      else if (cpu.cpu_rd)         ovf <= 1'b0;
      if (wd_hit)                  tmo <= 1'b1;
      else if (cpu.cpu_rd)         tmo <= 1'b0;
    end
  end

  always_comb begin
    cpu.cpu_dout             = 8'h00;
    cpu.cpu_dout[ST_EMPTY]   = fifo_empty;
    cpu.cpu_dout[ST_FULL]    = fifo_full;
    cpu.cpu_dout[ST_SENDING] = (state != IDLE);
    cpu.cpu_dout[ST_BUSY]    = busy_sync;
    cpu.cpu_dout[ST_TIMEOUT] = tmo;
    cpu.cpu_dout[ST_OVF]     = ovf;
  end
endmodule

// File: tb/tb_snd_cmd_sender.sv
// Scoreboard bench for snd_cmd_sender with a simple sound-board busy model.
module tb_snd_cmd_sender;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snd_cmd_sender_if cpu_if ();
  logic       model_busy = 1'b0, hold_busy = 1'b0, model_en = 1'b0;
  logic       snd_busy;
  logic [7:0] data_out;
  logic       mcode, fifo_full, fifo_empty;
  assign snd_busy = model_busy | hold_busy;

`ifdef SND_CMD_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 65535;
`endif

  snd_cmd_sender #(.DEPTH(4), .SETUP_CYC(2), .STROBE_CYC(4), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (cpu_if),
    .SND_BUSY   (snd_busy),
    .data_out   (data_out),
    .MCODE      (mcode),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty)
  );

  logic [7:0] exp_q [$];
  int n_vec = 0, n_err = 0, n_rise = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sound board: raise busy 3 cycles after MCODE rises, clear it 20 cycles later
  initial forever begin
    @(posedge mcode);
    if (model_en) begin
      repeat (3) @(posedge clk);
      model_busy = 1'b1;
      repeat (20) @(posedge clk);
      model_busy = 1'b0;
    end
  end

  // Monitor: every MCODE pulse must carry the next expected byte
  logic       mon_prev = 1'b0, mon_in = 1'b0, mon_stable = 1'b1;
  int         mon_width = 0;
  logic [7:0] mon_held = 8'h00;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mon_in   = 1'b0;
      mon_prev = mcode;
    end else begin
      if (mcode && !mon_prev) begin
        n_rise++;
        mon_in = 1'b1; mon_width = 0; mon_stable = 1'b1; mon_held = data_out;
        check("pulse_expected", 16'(exp_q.size() != 0), 16'd1);
        if (exp_q.size() != 0) check("data_at_rise", 16'(data_out), 16'(exp_q.pop_front()));
        check("busy_low_at_rise", 16'(snd_busy), 16'd0);
      end
      if (mon_in && mcode) begin
        mon_width++;
        if (data_out !== mon_held) mon_stable = 1'b0;
      end
      if (mon_in && !mcode) begin
        check("strobe_width", 16'(mon_width), 16'd4);
        check("data_stable", 16'(mon_stable), 16'd1);
        mon_in = 1'b0;
      end
      mon_prev = mcode;
    end
  end

  task automatic cpu_write(input logic [7:0] b, input bit accepted);
    @(negedge clk);
    cpu_if.cpu_wr = 1'b1; cpu_if.cpu_din = b;
    if (accepted) exp_q.push_back(b);
    @(negedge clk);
    cpu_if.cpu_wr = 1'b0;
  endtask

  task automatic status_read(output logic [7:0] s);
    @(negedge clk);
    s = cpu_if.cpu_dout;
    cpu_if.cpu_rd = 1'b1;
    @(negedge clk);
    cpu_if.cpu_rd = 1'b0;
  endtask

  task automatic wait_status(input logic [7:0] want, input int budget, input string name);
    int n = 0;
    while (cpu_if.cpu_dout !== want && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 16'(cpu_if.cpu_dout), 16'(want));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [7:0] st;
    int r0, n;
    cpu_if.cpu_wr = 1'b0; cpu_if.cpu_rd = 1'b0; cpu_if.cpu_din = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_data_out", 16'(data_out), 16'h00);
    check("rst_mcode", 16'(mcode), 16'd0);
    check("rst_empty", 16'(fifo_empty), 16'd1);
    check("rst_full", 16'(fifo_full), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_status", 16'(cpu_if.cpu_dout), 16'h01);

    // Single byte with handshaking sound board
    model_en = 1'b1;
    cpu_write(8'h5A, 1'b1);
    wait_status(8'h01, 200, "single_idle_status");
    check("single_delivered", 16'(exp_q.size()), 16'd0);
    check("single_pulses", 16'(n_rise), 16'd1);

    // Burst into a full FIFO while the sound board is held busy
    hold_busy = 1'b1;
    repeat (3) @(negedge clk);
    cpu_write(8'h11, 1'b1); cpu_write(8'h22, 1'b1);
    cpu_write(8'h33, 1'b1);
    check("not_full_after_3", 16'(fifo_full), 16'd0);
    cpu_write(8'h44, 1'b1);
    check("full_after_4", 16'(fifo_full), 16'd1);
    cpu_write(8'h55, 1'b0);
    status_read(st);
    check("status_overflow", 16'(st), 16'h8A);
    status_read(st);
    check("status_ovf_cleared", 16'(st), 16'h0A);
    r0 = n_rise;
    hold_busy = 1'b0;
    wait_status(8'h01, 800, "burst_idle_status");
    check("burst_delivered", 16'(exp_q.size()), 16'd0);
    check("burst_pulses", 16'(n_rise - r0), 16'd4);

    // Sound board already busy when the byte is written
    hold_busy = 1'b1;
    repeat (3) @(negedge clk);
    r0 = n_rise;
    cpu_write(8'h77, 1'b1);
    repeat (10) @(negedge clk);
    check("no_pulse_while_busy", 16'(n_rise), 16'(r0));
    check("status_busy_pending", 16'(cpu_if.cpu_dout), 16'h08);
    hold_busy = 1'b0;
    wait_status(8'h01, 200, "busy_release_idle");
    check("busy_release_pulses", 16'(n_rise - r0), 16'd1);

    // Reset during STROBE with a second byte queued
    model_en = 1'b0;
    cpu_write(8'hA5, 1'b1);
    cpu_write(8'hB6, 1'b0);
    n = 0;
    while (!mcode && n < 20) begin @(negedge clk); n++; end
    check("strobe_reached", 16'(mcode), 16'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_mcode", 16'(mcode), 16'd0);
    check("rst_mid_empty", 16'(fifo_empty), 16'd1);
    check("rst_mid_data", 16'(data_out), 16'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_status", 16'(cpu_if.cpu_dout), 16'h01);
    model_en = 1'b1;
    cpu_write(8'hC3, 1'b1);
    wait_status(8'h01, 200, "post_reset_idle");
    check("post_reset_delivered", 16'(exp_q.size()), 16'd0);

`ifdef SND_CMD_TIMEOUT_EN
    // Sound board never answers: watchdog releases each byte
    model_en = 1'b0;
    cpu_write(8'h3C, 1'b1);
    cpu_write(8'h4D, 1'b1);
    n = 0;
    while (!mcode && n < 30) begin @(negedge clk); n++; end
    while (mcode && n < 30) begin @(negedge clk); n++; end
    n = 0;
    while (!cpu_if.cpu_dout[6] && n < 200) begin @(negedge clk); n++; end
    check("timeout_latency", 16'(n), 16'd100);
    wait_status(8'h41, 400, "timeout_next_sent");
    check("timeout_delivered", 16'(exp_q.size()), 16'd0);
    status_read(st);
    check("timeout_cleared", 16'(cpu_if.cpu_dout), 16'h01);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/snd_cmd_sender.md
Name: snd_cmd_sender

Overview:
- Main-CPU-side transmitter for the sound command latch.
- Accepts command bytes from the main CPU bus into a small FIFO.
- Presents each byte on the latch data bus, pulses MCODE, then waits for the sound board to raise and later clear SND_BUSY before sending the next byte.
- Replaces a bare write-strobe, so back-to-back CPU writes cannot overrun the single latch.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- SETUP_CYC, 2, clk cycles data_out is stable before the MCODE rising edge.
- STROBE_CYC, 4, clk cycles MCODE is held high.
- TIMEOUT_CYC, 65535, watchdog limit in clk cycles; used only with SND_CMD_TIMEOUT_EN.

Ports:
- clk, in, 1, system clock 53.6MHz.
- rst, in, 1, asynchronous active-high reset.
- cpu_wr, in, 1, one-cycle write strobe: push cpu_din.
- cpu_din, in, 8, command byte.
- cpu_rd, in, 1, one-cycle status read strobe.
- cpu_dout, out, 8, status: {overflow, timeout, 2'b0, busy_sync, sending, full, empty}.
- SND_BUSY, in, 1, busy flag from the sound board.
- data_out, out, 8, latch data bus to the sound board.
- MCODE, out, 1, latch/IRQ strobe, rising-edge significant.
- fifo_full, out, 1, FIFO full.
- fifo_empty, out, 1, FIFO empty.

Behaviour:
Reset (async assert, release on clk):
- data_out=8'h00, MCODE=0, fifo_empty=1, fifo_full=0.
- Flags cleared; FSM=IDLE; pointers=0.

SND_BUSY input:
- Passed through a 2-FF synchroniser to give busy_sync.
- All FSM decisions use busy_sync.

FIFO:
- Pointers are log2(DEPTH)+1 bits, wrap-around.
- full when pointers differ only in MSB; empty when equal.
- Push when cpu_wr && !full.
- cpu_wr while full: byte dropped, sticky overflow set.
- Pop happens only on the IDLE->SETUP transition.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.

FSM:
- IDLE:
  - if !empty && !busy_sync: pop head into data_out, counter=0, go to SETUP.
  - if busy_sync at entry (sound board still busy from an earlier source), stay.
- SETUP:
  - MCODE=0; count SETUP_CYC cycles.
  - Then MCODE=1, go to STROBE.
- STROBE:
  - MCODE=1 for STROBE_CYC cycles.
  - Then MCODE=0, go to WAIT_SET.
- WAIT_SET:
  - wait for busy_sync=1 (receiver latched), then go to WAIT_CLR.
- WAIT_CLR:
  - wait for busy_sync=0 (sound CPU read its clear address), then go to IDLE.

Data and timing:
- data_out is held stable from SETUP until the next pop; it never changes while MCODE=1.
- Minimum latency from write into an empty FIFO (busy low) to MCODE rise: 1 (push) + 1 (pop) + SETUP_CYC cycles.
- sending = (state != IDLE).

Status read:
- cpu_dout is combinational from current flags.
- cpu_rd clears overflow and timeout on the following clk edge.
- A new overflow in the same cycle as cpu_rd wins, and the flag stays set.

Reset mid-transfer:
- MCODE drops immediately (async).
- FIFO contents are discarded.

Optional Feature:
SND_CMD_TIMEOUT_EN
- Defined:
  - a 16-bit watchdog counts cycles spent in WAIT_SET plus WAIT_CLR.
  - On reaching TIMEOUT_CYC: set sticky timeout flag, go to IDLE; the byte is considered sent.
  - Counter resets on every SETUP entry.
- Undefined:
  - no counter; WAIT states block indefinitely.
  - timeout status bit reads 0.

Decomposition:
- Package snd_cmd_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, WAIT_SET, WAIT_CLR);
  - status bit-index localparams (ST_EMPTY=0, ST_FULL=1, ST_SENDING=2, ST_BUSY=3, ST_TIMEOUT=6, ST_OVF=7).
- Sub-module: snd_cmd_fifo, a synchronous FIFO with DEPTH parameter and full/empty outputs, instantiated once.

Test Plan:
- Single write 0x5A with SND_BUSY model raising 3 cycles after MCODE and clearing 20 cycles later:
  - data_out=0x5A before MCODE rise;
  - MCODE high exactly 4 cycles;
  - FSM returns to IDLE;
  - status reads 0x01.
- Burst writes 0x11,0x22,0x33,0x44,0x55 with DEPTH=4 while busy is held high:
  - fifo_full after the 4th write;
  - 0x55 dropped; status bit7=1;
  - after cpu_rd, bit7=0;
  - bytes delivered in order 0x11..0x44, one MCODE pulse each, each only after busy clears.
- SND_BUSY already high at write time: no MCODE until busy_sync falls, then a normal pulse.
- Assert rst during STROBE:
  - MCODE=0 in the same cycle;
  - fifo_empty=1, data_out=0x00;
  - after release, a new write transfers normally.
- With SND_CMD_TIMEOUT_EN and TIMEOUT_CYC=100, SND_BUSY tied low after a write:
  - timeout flag (bit6) set 100 cycles after entering WAIT_SET;
  - the next queued byte is then sent.
